// File: rtl/debug_ctrl.sv
// debug_ctrl: halt/resume/single-step controller with an optional debug
// register-read port.
// Build option: define DEBUG_CTRL_READ_EN to include the register-read path.
// Without it, rf_rs1 always follows IF_ID_rs1 and rd_ack/rd_data are tied to 0.
// Handshake: rd_req is a level held by the requester until it sees rd_ack.
// A read is granted only in HALTED while rd_ack is low. The granted data
// appears on rd_data together with a one-cycle rd_ack on the following cycle.
module debug_ctrl (
  input  logic        clk,
  input  logic        Rst,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        step_req,
  input  logic        hz,
  input  logic        branch_taken,
  input  logic        rd_req,
  input  logic [4:0]  rd_adr,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [31:0] rf_dout_rs1,
  output logic [4:0]  rf_rs1,
  output logic [31:0] rd_data,
  output logic        rd_ack,
  output logic        debug,
  output logic        halted,
  output logic        drain_timeout,
  output logic [15:0] step_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] drain_cnt;
  logic       resume_pend;
  logic       step_pend;
  logic       rd_grant;
  logic       resume_eff;
  logic       step_eff;

  // A pulse arriving this cycle counts the same as one already pending.
  assign resume_eff = resume_pend | resume_req;
  assign step_eff   = step_pend | step_req;

`ifdef DEBUG_CTRL_READ_EN
  // Grant only while halted, never in the rd_ack cycle.
  assign rd_grant = (state == ST_HALTED) && rd_req && !rd_ack;
  assign rf_rs1   = rd_grant ? rd_adr : IF_ID_rs1;

  // Capture the register-file data on a grant and strobe rd_ack next cycle.
  always_ff @(posedge clk) begin
    if (Rst) begin
      rd_ack  <= 1'b0;
      rd_data <= 32'h0;
    end else begin
      rd_ack <= rd_grant;
      if (rd_grant) rd_data <= rf_dout_rs1;
    end
  end
`else
  logic unused_read_inputs;
  assign unused_read_inputs = ^{rd_req, rd_adr, rf_dout_rs1};
  assign rd_grant = 1'b0;
  assign rf_rs1   = IF_ID_rs1;
  assign rd_ack   = 1'b0;
  assign rd_data  = 32'h0;
`endif

  // Control FSM; debug/halted are registered alongside each transition.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state         <= ST_RUN;
      drain_cnt     <= 4'd0;
      resume_pend   <= 1'b0;
      step_pend     <= 1'b0;
      debug         <= 1'b0;
      halted        <= 1'b0;
      drain_timeout <= 1'b0;
      step_cnt      <= 16'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_req) begin
            state     <= ST_DRAIN;
            drain_cnt <= 4'd0;
          end
        end
        ST_DRAIN: begin
          if (resume_req) begin
            state <= ST_RUN;
          end else if (!hz && !branch_taken) begin
            state  <= ST_HALTED;
            debug  <= 1'b1;
            halted <= 1'b1;
          end else if (drain_cnt == 4'd15) begin
            state         <= ST_HALTED;
            debug         <= 1'b1;
            halted        <= 1'b1;
            drain_timeout <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        ST_HALTED: begin
          if (rd_grant) begin
            // Read wins this cycle; remember any requests for later.
            resume_pend <= resume_eff;
            step_pend   <= step_eff;
          end else if (resume_eff) begin
            state         <= ST_RUN;
            resume_pend   <= 1'b0;
            step_pend     <= 1'b0;
            drain_timeout <= 1'b0;
            debug         <= 1'b0;
            halted        <= 1'b0;
          end else if (step_eff) begin
            state     <= ST_STEP;
            step_pend <= 1'b0;
            debug     <= 1'b0;
            halted    <= 1'b0;
          end
        end
        ST_STEP: begin
          state    <= ST_HALTED;
          step_cnt <= step_cnt + 16'd1;
          debug    <= 1'b1;
          halted   <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          debug  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Testbench for debug_ctrl. Works in both builds (DEBUG_CTRL_READ_EN defined or not).
module tb_debug_ctrl;

`ifdef DEBUG_CTRL_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk;
  logic        Rst;
  logic        halt_req, resume_req, step_req, hz, branch_taken, rd_req;
  logic [4:0]  rd_adr, IF_ID_rs1, rf_rs1;
  logic [31:0] rf_dout_rs1, rd_data;
  logic        rd_ack, debug, halted, drain_timeout;
  logic [15:0] step_cnt;

  int n_asserts = 0;
  int n_fail = 0;
  logic [15:0] exp_cnt;
  logic [31:0] exp_data;
  logic [31:0] exp_q[$];

  debug_ctrl dut (
    .clk(clk), .Rst(Rst), .halt_req(halt_req), .resume_req(resume_req),
    .step_req(step_req), .hz(hz), .branch_taken(branch_taken),
    .rd_req(rd_req), .rd_adr(rd_adr), .IF_ID_rs1(IF_ID_rs1),
    .rf_dout_rs1(rf_dout_rs1), .rf_rs1(rf_rs1), .rd_data(rd_data),
    .rd_ack(rd_ack), .debug(debug), .halted(halted),
    .drain_timeout(drain_timeout), .step_cnt(step_cnt)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Halt request, then drive per-cycle hazard bits. Halt happens on the first
  // clean cycle, or after the 16th hazardous drain cycle with the timeout flag.
  task automatic run_drain(input logic [15:0] hzb, input logic [15:0] brb);
    int   k;
    logic to;
    k  = 15;
    to = 1'b1;
    for (int i = 15; i >= 0; i--)
      if (!hzb[i] && !brb[i]) begin
        k  = i;
        to = 1'b0;
      end
    halt_req = 1'b1; hz = 1'b1; branch_taken = 1'b0;
    tick();
    halt_req = 1'b0;
    chk("drain_entry_halted", {31'h0, halted}, 32'h0);
    chk("drain_entry_debug", {31'h0, debug}, 32'h0);
    for (int i = 0; i <= k; i++) begin
      hz = hzb[i]; branch_taken = brb[i];
      tick();
      chk("drain_halted", {31'h0, halted}, {31'h0, i == k});
    end
    chk("halted_debug", {31'h0, debug}, 32'h1);
    chk("drain_timeout", {31'h0, drain_timeout}, {31'h0, to});
    hz = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic do_resume();
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk("resume_halted", {31'h0, halted}, 32'h0);
    chk("resume_debug", {31'h0, debug}, 32'h0);
    chk("resume_timeout", {31'h0, drain_timeout}, 32'h0);
  endtask

  task automatic do_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_debug_low", {31'h0, debug}, 32'h0);
    chk("step_halted_low", {31'h0, halted}, 32'h0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("step_debug_back", {31'h0, debug}, 32'h1);
    chk("step_cnt", {16'h0, step_cnt}, {16'h0, exp_cnt});
    tick();
    tick();
    chk("step_debug_held", {31'h0, debug}, 32'h1);
  endtask

  // Single read while halted; checks grant mux, ack strobe, capture and hold.
  task automatic do_read(input logic [4:0] adr, input logic [31:0] data);
    logic [4:0] ifid;
    ifid = 5'($urandom);
    rd_req = 1'b1; rd_adr = adr; rf_dout_rs1 = data; IF_ID_rs1 = ifid;
    #1;
    chk("read_grant_mux", {27'h0, rf_rs1}, {27'h0, READ_EN ? adr : ifid});
    tick();
    exp_data = READ_EN ? data : 32'h0;
    rf_dout_rs1 = ~data;
    #1;
    chk("read_ack", {31'h0, rd_ack}, {31'h0, READ_EN});
    chk("read_data", rd_data, exp_data);
    chk("read_ack_cycle_mux", {27'h0, rf_rs1}, {27'h0, ifid});
    rd_req = 1'b0;
    tick();
    chk("read_ack_one_cycle", {31'h0, rd_ack}, 32'h0);
    chk("read_data_hold", rd_data, exp_data);
  endtask

  initial begin
    logic [4:0]  adr;
    logic [31:0] d;
    Rst = 1'b1; halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    hz = 1'b0; branch_taken = 1'b0; rd_req = 1'b0; rd_adr = 5'd0;
    IF_ID_rs1 = 5'd3; rf_dout_rs1 = 32'h0;
    exp_cnt = 16'h0; exp_data = 32'h0;

    // reset values
    tick(); tick();
    chk("rst_debug", {31'h0, debug}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_rd_ack", {31'h0, rd_ack}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_timeout", {31'h0, drain_timeout}, 32'h0);
    chk("rst_step_cnt", {16'h0, step_cnt}, 32'h0);
    chk("rst_rf_rs1", {27'h0, rf_rs1}, 32'd3);
    Rst = 1'b0;

    // RUN ignores resume/step, and never grants reads
    resume_req = 1'b1; step_req = 1'b1;
    tick();
    resume_req = 1'b0; step_req = 1'b0;
    tick();
    chk("run_ignore_halted", {31'h0, halted}, 32'h0);
    chk("run_ignore_cnt", {16'h0, step_cnt}, 32'h0);
    rd_req = 1'b1; rd_adr = 5'd7; rf_dout_rs1 = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      IF_ID_rs1 = 5'($urandom);
      #1;
      chk("run_rf_rs1_tracks", {27'h0, rf_rs1}, {27'h0, IF_ID_rs1});
      tick();
      chk("run_no_ack", {31'h0, rd_ack}, 32'h0);
    end
    rd_req = 1'b0;

    // halt with no hazard: two edges to HALTED, no timeout
    run_drain(16'h0000, 16'h0000);

    // halt_req ignored while halted
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    chk("halted_ignore_halt", {31'h0, halted}, 32'h1);

    // directed debug read
    do_read(5'd7, 32'hDEADBEEF);

    // held request: served on every second cycle
    for (int b = 0; b < 3; b++) begin
      adr = 5'($urandom);
      rd_req = 1'b1; rd_adr = adr;
      for (int i = 0; i < 6; i++) begin
        d = $urandom;
        rf_dout_rs1 = d;
        IF_ID_rs1 = 5'($urandom);
        #1;
        chk("burst_mux", {27'h0, rf_rs1},
            {27'h0, (READ_EN && (i % 2 == 0)) ? adr : IF_ID_rs1});
        if (READ_EN && (i % 2 == 0)) exp_q.push_back(d);
        tick();
        chk("burst_ack", {31'h0, rd_ack}, {31'h0, READ_EN && (i % 2 == 0)});
        if (exp_q.size() > 0) exp_data = exp_q.pop_front();
        chk("burst_data", rd_data, exp_data);
        chk("burst_still_halted", {31'h0, halted}, 32'h1);
      end
      rd_req = 1'b0;
      tick();
    end

    // three steps four cycles apart
    for (int i = 0; i < 3; i++) do_step();

    // step deferred behind a read grant
    rd_req = 1'b1; rd_adr = 5'd9; rf_dout_rs1 = 32'h12345678; step_req = 1'b1;
    tick();
    step_req = 1'b0; rd_req = 1'b0;
    chk("defer_step_t1", {31'h0, debug}, {31'h0, READ_EN});
    tick();
    chk("defer_step_t2", {31'h0, debug}, {31'h0, !READ_EN});
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("defer_step_t3", {31'h0, debug}, 32'h1);
    chk("defer_step_cnt", {16'h0, step_cnt}, {16'h0, exp_cnt});
    tick();

    // counter wrap from 0xFFFF
    force dut.step_cnt = 16'hFFFF;
    tick();
    release dut.step_cnt;
    exp_cnt = 16'hFFFF;
    do_step();

    // collision: read wins, then resume beats step
    d = $urandom;
    rd_req = 1'b1; rd_adr = 5'd4; rf_dout_rs1 = d;
    resume_req = 1'b1; step_req = 1'b1;
    tick();
    resume_req = 1'b0; step_req = 1'b0;
    chk("coll_ack", {31'h0, rd_ack}, {31'h0, READ_EN});
    chk("coll_data", rd_data, READ_EN ? d : 32'h0);
    chk("coll_halted_t1", {31'h0, halted}, {31'h0, READ_EN});
    rd_req = 1'b0;
    tick();
    chk("coll_halted_t2", {31'h0, halted}, 32'h0);
    chk("coll_debug_t2", {31'h0, debug}, 32'h0);
    tick();
    tick();
    chk("coll_still_run", {31'h0, halted}, 32'h0);
    chk("coll_step_cnt", {16'h0, step_cnt}, {16'h0, exp_cnt});

    // drain timeout, then resume clears it
    run_drain(16'hFFFF, 16'h0000);
    do_resume();

    // resume during drain cancels the halt, even on a clean cycle
    halt_req = 1'b1; hz = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < int'($urandom_range(1, 10)); i++) tick();
    chk("cancel_pre_halted", {31'h0, halted}, 32'h0);
    hz = 1'b0; resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    tick(); tick();
    chk("cancel_halted", {31'h0, halted}, 32'h0);
    chk("cancel_debug", {31'h0, debug}, 32'h0);

    // random hazard patterns
    for (int r = 0; r < 6; r++) begin
      run_drain(16'($urandom | $urandom), 16'($urandom & $urandom));
      do_resume();
      tick();
    end

    // reset in the STEP cycle with every request asserted
    run_drain(16'hFFFF, 16'hFFFF);
    do_read(5'd11, 32'hCAFEF00D);
    do_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("pre_rst_in_step", {31'h0, debug}, 32'h0);
    Rst = 1'b1; halt_req = 1'b1; resume_req = 1'b1; step_req = 1'b1; rd_req = 1'b1;
    tick();
    Rst = 1'b0; halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; rd_req = 1'b0;
    exp_cnt = 16'h0;
    chk("mid_rst_debug", {31'h0, debug}, 32'h0);
    chk("mid_rst_halted", {31'h0, halted}, 32'h0);
    chk("mid_rst_rd_ack", {31'h0, rd_ack}, 32'h0);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    chk("mid_rst_timeout", {31'h0, drain_timeout}, 32'h0);
    chk("mid_rst_step_cnt", {16'h0, step_cnt}, 32'h0);
    hz = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_run", {31'h0, halted}, 32'h0);
    hz = 1'b0;
    run_drain(16'h0000, 16'h0000);
    do_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
